// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit.
//   RV_NOP       : canonical RV32 NOP (addi x0,x0,0) shown on ID while the queue is empty
//   ifp_state_e  : fetch FSM states (FETCH = normal fetching, DRAIN = finishing an abandoned access)
//   cnt_width()  : width of an occupancy counter able to hold 0..depth
package if_prefetch_unit_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    IFP_FETCH = 1'b0,
    IFP_DRAIN = 1'b1
  } ifp_state_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bus bundle between the prefetch unit, instruction memory, EX (redirects) and ID.
//   IMEM_READ/IMEM_ADDR          : request to instruction memory
//   IMEM_RDATA/IMEM_BUSYWAIT     : memory response; data valid when READ && !BUSYWAIT
//   REDIRECT_EN/REDIRECT_PC      : taken branch/jump from EX
//   ID_HOLD                      : ID cannot accept (load-use hazard)
//   ID_VALID/ID_PC/ID_INSTR      : head instruction presented to ID
// master = prefetch unit side, slave = environment (memory + pipeline) side.
interface if_prefetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            IMEM_READ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic [31:0]     IMEM_RDATA;
  logic            IMEM_BUSYWAIT;
  logic            REDIRECT_EN;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            ID_HOLD;
  logic            ID_VALID;
  logic [XLEN-1:0] ID_PC;
  logic [31:0]     ID_INSTR;

  modport master (
    output IMEM_READ, IMEM_ADDR,
    input  IMEM_RDATA, IMEM_BUSYWAIT,
    input  REDIRECT_EN, REDIRECT_PC, ID_HOLD,
    output ID_VALID, ID_PC, ID_INSTR
  );

  modport slave (
    input  IMEM_READ, IMEM_ADDR,
    output IMEM_RDATA, IMEM_BUSYWAIT,
    output REDIRECT_EN, REDIRECT_PC, ID_HOLD,
    input  ID_VALID, ID_PC, ID_INSTR
  );

endinterface

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO used as the prefetch queue.
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : write i_wdata (ignored when full unless a pop happens in the same cycle)
//   i_pop      : drop the head entry (ignored when empty)
//   i_flush    : empty the queue; overrides push/pop
//   o_rdata    : head entry, combinational from storage
//   o_count    : occupancy 0..DEPTH
//   o_full/o_empty : occupancy flags
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
//   CLK    : clock, rising edge
//   RESET  : synchronous, active-high
//   bus    : if_prefetch_unit_if.master -- IMEM request/response, EX redirect,
//            ID hold, and the head instruction presented to ID
// One IMEM request is outstanding at a time. A redirect that lands while the
// memory is stalling moves the FSM to DRAIN, which keeps the stale request on
// the bus until it completes and then throws the data away.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = RV_NOP
) (
  input logic                CLK,
  input logic                RESET,
  if_prefetch_unit_if.master bus
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned QW = XLEN + 32;

  ifp_state_e      r_state;
  ifp_state_e      w_state_nxt;
  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] w_fpc_nxt;
  logic [XLEN-1:0] r_stale_addr;
  logic [XLEN-1:0] w_stale_nxt;
  logic [XLEN-1:0] w_redir_pc;

  logic            w_req;
  logic [XLEN-1:0] w_addr;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic [QW-1:0]   w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_valid;

  assign w_redir_pc = {bus.REDIRECT_PC[XLEN-1:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= IFP_FETCH;
      r_fpc        <= {RESET_PC[XLEN-1:2], 2'b00};
      r_stale_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fpc        <= w_fpc_nxt;
      r_stale_addr <= w_stale_nxt;
    end
  end

  // RESET is folded in combinationally so the memory request and ID view are
  // quiet during any cycle with RESET high, including one that aborts a drain.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_stale_nxt = r_stale_addr;
    w_req       = 1'b0;
    w_addr      = r_fpc;
    w_push      = 1'b0;
    w_flush     = 1'b0;

    unique case (r_state)
      IFP_FETCH: begin
        // a request never starts when full, so count stays below DEPTH for its whole stall
        w_req  = !w_full;
        w_addr = r_fpc;
        if (bus.REDIRECT_EN) begin
          w_flush   = 1'b1;
          w_fpc_nxt = w_redir_pc;
          if (w_req && bus.IMEM_BUSYWAIT) begin
            w_state_nxt = IFP_DRAIN;
            w_stale_nxt = r_fpc;
          end
        end else if (w_req && !bus.IMEM_BUSYWAIT) begin
          w_push    = 1'b1;
          w_fpc_nxt = r_fpc + XLEN'(4);
        end
      end
      IFP_DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_stale_addr;
        if (!bus.IMEM_BUSYWAIT) w_state_nxt = IFP_FETCH;
        if (bus.REDIRECT_EN) begin
          w_flush   = 1'b1;
          w_fpc_nxt = w_redir_pc;
        end
      end
      default: begin
        w_state_nxt = IFP_FETCH;
      end
    endcase

    if (RESET) begin
      w_req   = 1'b0;
      w_push  = 1'b0;
      w_flush = 1'b0;
    end
  end

  assign w_valid = !RESET && (w_count != '0);
  assign w_pop   = w_valid && !bus.ID_HOLD && !bus.REDIRECT_EN;

  sync_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata ({r_fpc, bus.IMEM_RDATA}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.IMEM_READ = w_req;
  assign bus.IMEM_ADDR = w_addr;
  assign bus.ID_VALID  = w_valid;
  assign bus.ID_PC     = w_valid ? w_head[QW-1:32] : '0;
  assign bus.ID_INSTR  = w_valid ? w_head[31:0]    : NOP_INSTR;

  queue_flags_consistent: assert property (@(posedge CLK) disable iff (RESET)
    w_empty == (w_count == '0));

endmodule

// File: tb/tb_if_prefetch_unit.sv
module tb_if_prefetch_unit;
  import if_prefetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RESET;

  if_prefetch_unit_if #(.XLEN(32)) bus ();

  if_prefetch_unit #(
    .XLEN      (32),
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'hA5A5_0000) | 32'h0000_0003;
  endfunction

  // memory model: address-derived data, optional stall of N cycles on one address
  logic [31:0] bw_addr    = 32'hFFFF_FFFF;
  int unsigned bw_left    = 0;
  logic [31:0] arm_addr   = 32'h0;
  int unsigned arm_cycles = 0;
  int unsigned arm_id     = 0;
  int unsigned arm_seen   = 0;

  assign bus.IMEM_RDATA    = word_of(bus.IMEM_ADDR);
  assign bus.IMEM_BUSYWAIT = bus.IMEM_READ && (bus.IMEM_ADDR == bw_addr) && (bw_left != 0);

  always @(posedge CLK) begin
    if (arm_id != arm_seen) begin
      arm_seen <= arm_id;
      bw_addr  <= arm_addr;
      bw_left  <= arm_cycles;
    end else if (bus.IMEM_BUSYWAIT) begin
      bw_left <= bw_left - 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic arm(input logic [31:0] a, input int unsigned n);
    arm_addr   = a;
    arm_cycles = n;
    arm_id     = arm_id + 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // scoreboard monitor: every instruction ID accepts must be the next expected PC
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b0) begin
        if (bus.ID_VALID && !bus.ID_HOLD && !bus.REDIRECT_EN) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: ID_PC=0x%08h with no entry expected", bus.ID_PC);
          end else begin
            e = exp_q.pop_front();
            chk("pop_pc", bus.ID_PC, e);
            chk("pop_instr", bus.ID_INSTR, word_of(e));
          end
        end else if (!bus.ID_VALID) begin
          chk("idle_nop", bus.ID_INSTR, NOP);
        end
      end
    end
  endtask

  task automatic run_tests();
    int n;
    int p0;
    bus.ID_HOLD     = 1'b0;
    bus.REDIRECT_EN = 1'b0;
    bus.REDIRECT_PC = 32'h0;
    RESET           = 1'b1;

    // 1: reset state, then zero-wait streaming from RESET_PC
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_read",  32'(bus.IMEM_READ), 32'd0);
    chk("rst_valid", 32'(bus.ID_VALID),  32'd0);
    chk("rst_instr", bus.ID_INSTR,       NOP);
    chk("rst_pc",    bus.ID_PC,          32'h0);
    expect_stream(32'h0, 64);
    tick(); RESET = 1'b0;
    @(negedge CLK);
    chk("t1_c0_valid", 32'(bus.ID_VALID),  32'd0);
    chk("t1_c0_read",  32'(bus.IMEM_READ), 32'd1);
    chk("t1_c0_addr",  bus.IMEM_ADDR,      32'h0);
    @(negedge CLK);
    chk("t1_c1_valid", 32'(bus.ID_VALID),  32'd1);
    repeat (6) @(negedge CLK);

    // 2: ID_HOLD from reset fills exactly DEPTH entries, release drains in order
    tick(); RESET = 1'b1; bus.ID_HOLD = 1'b1; expect_stream(32'h0, 64);
    tick(); RESET = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.IMEM_READ && !bus.IMEM_BUSYWAIT) n++;
    end
    chk("t2_fetches",  32'(n),             32'd4);
    chk("t2_read_off", 32'(bus.IMEM_READ), 32'd0);
    chk("t2_valid",    32'(bus.ID_VALID),  32'd1);
    chk("t2_head",     bus.ID_PC,          32'h0);
    p0 = pops;
    tick(); bus.ID_HOLD = 1'b0;
    repeat (8) @(negedge CLK);
    chk("t2_pops", 32'(pops - p0), 32'd8);

    // 3: 3-cycle stall on 0x8 keeps the request stable
    tick(); RESET = 1'b1; arm(32'h8, 3); expect_stream(32'h0, 64);
    tick(); RESET = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.IMEM_BUSYWAIT) begin
        n++;
        chk("t3_addr_stable", bus.IMEM_ADDR,      32'h8);
        chk("t3_read_held",   32'(bus.IMEM_READ), 32'd1);
      end
    end
    chk("t3_stall_cycles", 32'(n), 32'd3);
    repeat (4) @(negedge CLK);

    // 4: redirect to 0x100 while 0x10 is stalled -> drain 0x10, then fetch 0x100
    tick(); RESET = 1'b1; arm(32'h10, 3); expect_stream(32'h0, 64);
    tick(); RESET = 1'b0;
    n = 0;
    while (!bus.IMEM_BUSYWAIT && n < 20) begin tick(); n++; end
    chk("t4_busy_seen", 32'(bus.IMEM_BUSYWAIT), 32'd1);
    chk("t4_busy_addr", bus.IMEM_ADDR,          32'h10);
    bus.REDIRECT_EN = 1'b1; bus.REDIRECT_PC = 32'h100; expect_stream(32'h100, 64);
    tick(); bus.REDIRECT_EN = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("t4_drain_addr", bus.IMEM_ADDR,      32'h10);
      chk("t4_drain_read", 32'(bus.IMEM_READ), 32'd1);
    end
    @(negedge CLK);
    chk("t4_drain_done",  32'(bus.IMEM_BUSYWAIT), 32'd0);
    chk("t4_drain_addr2", bus.IMEM_ADDR,          32'h10);
    chk("t4_drain_empty", 32'(bus.ID_VALID),      32'd0);
    @(negedge CLK);
    chk("t4_new_addr", bus.IMEM_ADDR,      32'h100);
    chk("t4_new_read", 32'(bus.IMEM_READ), 32'd1);
    repeat (5) @(negedge CLK);

    // 5: redirect to 0x203 in the cycle the last queue slot completes
    tick(); RESET = 1'b1; bus.ID_HOLD = 1'b1; exp_q.delete();
    tick(); RESET = 1'b0;
    repeat (3) tick();
    chk("t5_c3_addr",  bus.IMEM_ADDR,      32'hC);
    chk("t5_c3_read",  32'(bus.IMEM_READ), 32'd1);
    chk("t5_c3_valid", 32'(bus.ID_VALID),  32'd1);
    bus.REDIRECT_EN = 1'b1; bus.REDIRECT_PC = 32'h203; expect_stream(32'h200, 64);
    tick(); bus.REDIRECT_EN = 1'b0;
    @(negedge CLK);
    chk("t5_flushed", 32'(bus.ID_VALID),  32'd0);
    chk("t5_addr",    bus.IMEM_ADDR,      32'h200);
    chk("t5_read",    32'(bus.IMEM_READ), 32'd1);
    tick(); bus.ID_HOLD = 1'b0;
    repeat (6) @(negedge CLK);

    // 6: wrap past 0xFFFF_FFFC, then RESET while draining
    arm(32'h10, 5);
    tick();
    bus.REDIRECT_EN = 1'b1; bus.REDIRECT_PC = 32'hFFFF_FFF8; expect_stream(32'hFFFF_FFF8, 64);
    tick(); bus.REDIRECT_EN = 1'b0;
    n = 0;
    while (!(bus.IMEM_READ && !bus.IMEM_BUSYWAIT && bus.IMEM_ADDR == 32'hFFFF_FFFC) && n < 20) begin
      @(negedge CLK); n++;
    end
    chk("t6_top_seen", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    @(negedge CLK);
    chk("t6_wrap", bus.IMEM_ADDR, 32'h0);
    n = 0;
    while (!bus.IMEM_BUSYWAIT && n < 20) begin tick(); n++; end
    chk("t6_busy_addr", bus.IMEM_ADDR, 32'h10);
    bus.REDIRECT_EN = 1'b1; bus.REDIRECT_PC = 32'h300;
    tick(); bus.REDIRECT_EN = 1'b0; RESET = 1'b1; exp_q.delete(); arm(32'h10, 0);
    @(negedge CLK);
    chk("t6_rst_read",  32'(bus.IMEM_READ), 32'd0);
    chk("t6_rst_valid", 32'(bus.ID_VALID),  32'd0);
    expect_stream(32'h0, 64);
    tick(); RESET = 1'b0;
    @(negedge CLK);
    chk("t6_after_addr",  bus.IMEM_ADDR,      32'h0);
    chk("t6_after_read",  32'(bus.IMEM_READ), 32'd1);
    chk("t6_after_valid", 32'(bus.ID_VALID),  32'd0);
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        #50000;
        checks++;
        errors++;
        $display("FAIL watchdog: run did not finish within time limit");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
